// File: rtl/spike_count_decoder.sv
// Spike-count readout for the network's output layer: counts spikes per neuron over a
// window of timesteps, then scans the counters for the most active neuron.
module spike_count_decoder #(
  parameter int NUM_NEURONS  = 4,
  parameter int COUNT_WIDTH  = 16,
  parameter int WINDOW_WIDTH = 16,
  localparam int SEL_WIDTH   = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [WINDOW_WIDTH-1:0] window_len,
  input  logic [NUM_NEURONS-1:0]  spike_in,
  output logic                    busy,
  output logic                    result_valid,
  input  logic                    result_ready,
  output logic [SEL_WIDTH-1:0]    result_class,
  output logic [COUNT_WIDTH-1:0]  result_count,
  input  logic [SEL_WIDTH-1:0]    count_sel,
  output logic [COUNT_WIDTH-1:0]  count_dout
);

  localparam logic [SEL_WIDTH-1:0] LAST_IDX = SEL_WIDTH'(NUM_NEURONS - 1);

  typedef enum logic [1:0] {IDLE, RUN, SCAN, DONE} state_t;

  state_t                  state_q, state_d;
  logic [COUNT_WIDTH-1:0]  cnt_q [NUM_NEURONS];
  logic [WINDOW_WIDTH-1:0] win_q;
  logic [WINDOW_WIDTH-1:0] tstep_q;
  logic [SEL_WIDTH-1:0]    scan_idx_q;
  logic [SEL_WIDTH-1:0]    best_idx_q;
  logic [COUNT_WIDTH-1:0]  best_cnt_q;
  logic [SEL_WIDTH-1:0]    result_class_q;
  logic [COUNT_WIDTH-1:0]  result_count_q;

  logic                    accept;
  logic                    run_last;
  logic                    scan_last;
  logic [COUNT_WIDTH-1:0]  scan_cnt;
  logic                    take;
  logic [COUNT_WIDTH-1:0]  nxt_best_cnt;
  logic [SEL_WIDTH-1:0]    nxt_best_idx;

  function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
    return (v == '1) ? v : v + COUNT_WIDTH'(1);
  endfunction

  assign accept    = (state_q == IDLE) && start && (window_len != '0);
  // RUN holds one extra cycle after the last sample: tstep_q == win_q means all samples taken.
  assign run_last  = (tstep_q == win_q);
  assign scan_last = (scan_idx_q == LAST_IDX);

  assign scan_cnt     = cnt_q[scan_idx_q];
  assign take         = scan_cnt > best_cnt_q;
  assign nxt_best_cnt = take ? scan_cnt : best_cnt_q;
  assign nxt_best_idx = take ? scan_idx_q : best_idx_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept)       state_d = RUN;
      RUN:  if (run_last)     state_d = SCAN;
      SCAN: if (scan_last)    state_d = DONE;
      DONE: if (result_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // Accumulate / scan stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_NEURONS; i++) cnt_q[i] <= '0;
      win_q          <= '0;
      tstep_q        <= '0;
      scan_idx_q     <= '0;
      best_idx_q     <= '0;
      best_cnt_q     <= '0;
      result_class_q <= '0;
      result_count_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            for (int i = 0; i < NUM_NEURONS; i++) cnt_q[i] <= '0;
            win_q      <= window_len;
            tstep_q    <= '0;
            scan_idx_q <= '0;
            best_idx_q <= '0;
            best_cnt_q <= '0;
          end
        end
        RUN: begin
          if (!run_last) begin
            for (int i = 0; i < NUM_NEURONS; i++)
              if (spike_in[i]) cnt_q[i] <= sat_inc(cnt_q[i]);
            tstep_q <= tstep_q + WINDOW_WIDTH'(1);
          end
        end
        SCAN: begin
          best_cnt_q <= nxt_best_cnt;
          best_idx_q <= nxt_best_idx;
          scan_idx_q <= scan_idx_q + SEL_WIDTH'(1);
          if (scan_last) begin
            result_class_q <= nxt_best_idx;
            result_count_q <= nxt_best_cnt;
          end
        end
        default: ;
      endcase
    end
  end

  // Output stage
  assign busy         = (state_q != IDLE);
  assign result_valid = (state_q == DONE);
  assign result_class = result_class_q;
  assign result_count = result_count_q;

  always_comb begin
    count_dout = '0;
    if (int'(count_sel) < NUM_NEURONS) count_dout = cnt_q[count_sel];
  end

endmodule

// File: doc/spike_count_decoder.md
SPIKE_COUNT_DECODER -- requirements
Module: spike_count_decoder

Interface
REQ-001 SHALL have parameter NUM_NEURONS, default 4: number of spike lines counted; this matches the output layer width of the network.
REQ-002 SHALL have parameter COUNT_WIDTH, default 16: width of each per-neuron spike counter.
REQ-003 SHALL have parameter WINDOW_WIDTH, default 16: width of the timestep window length.
REQ-004 SHALL have localparam SEL_WIDTH = max(1, $clog2(NUM_NEURONS)).
REQ-005 SHALL have port clk, input, 1 bit: the single clock.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous reset, active-high.
REQ-007 SHALL have port start, input, 1 bit: one-cycle request to begin a classification window.
REQ-008 SHALL have port window_len, input, WINDOW_WIDTH bits: number of timesteps to count, sampled on an accepted start.
REQ-009 SHALL have port spike_in, input, NUM_NEURONS bits: spike_out of the recurrent network.
REQ-010 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-011 SHALL have port result_valid, output, 1 bit: a classification result is held.
REQ-012 SHALL have port result_ready, input, 1 bit: consumer accepts the result.
REQ-013 SHALL have port result_class, output, SEL_WIDTH bits: index of the winning neuron.
REQ-014 SHALL have port result_count, output, COUNT_WIDTH bits: spike count of the winning neuron.
REQ-015 SHALL have port count_sel, input, SEL_WIDTH bits: counter readback select.
REQ-016 SHALL have port count_dout, output, COUNT_WIDTH bits: combinational readback of counter[count_sel], giving 0 when count_sel >= NUM_NEURONS.

Function
REQ-017 SHALL implement the FSM states IDLE, RUN, SCAN and DONE.
REQ-018 SHALL accept start only in IDLE with window_len != 0; on acceptance it SHALL clear all counters, latch window_len, clear the timestep counter and enter RUN.
REQ-019 SHALL ignore start in IDLE when window_len == 0, and SHALL ignore start in RUN, SCAN and DONE, with no state change.
REQ-020 In RUN, on each clock it SHALL add 1 to counter[i] for each i where spike_in[i] == 1, and SHALL increment the timestep counter.
REQ-021 Spike counters SHALL saturate at 2^COUNT_WIDTH-1 and SHALL never wrap.
REQ-022 RUN SHALL sample exactly window_len clock edges, then enter SCAN; spike_in outside RUN SHALL be ignored.
REQ-023 SCAN SHALL compare one neuron per cycle, in index order 0 to NUM_NEURONS-1, so it lasts exactly NUM_NEURONS cycles.
REQ-024 SCAN SHALL replace the running best only when the count is strictly greater, so on a tie the lowest index wins; all-zero counts SHALL give class 0 with count 0.
REQ-025 After SCAN the block SHALL enter DONE with result_valid = 1; result_class and result_count SHALL be stable while result_valid = 1.
REQ-026 Handshake: when result_valid && result_ready at a rising edge, the result SHALL be consumed and the next state SHALL be IDLE; result_valid SHALL stay high until then.
REQ-027 After the handshake, result_class and result_count SHALL keep their last values, and counters SHALL hold until the next accepted start.
REQ-028 Latency: if start is accepted at edge k, result_valid SHALL be first high after edge k + window_len + NUM_NEURONS + 1.
REQ-029 A start pulse in the same cycle as the DONE handshake SHALL be ignored; a new start is accepted only from IDLE.

Reset
REQ-030 On rst = 1 the block SHALL asynchronously enter IDLE and clear all counters, the timestep counter, result_class, result_count and the running best.
REQ-031 On reset, busy and result_valid SHALL be 0 immediately, without waiting for a clock edge.
REQ-032 Reset asserted during RUN or SCAN SHALL abandon the operation, and no result SHALL be produced.

Verification
REQ-033 N=4, W=10; spike_in = 4'b0100 every cycle of RUN -> result_class = 2, result_count = 10, result_valid first high 15 cycles after the start edge.
REQ-034 W=8; neuron 1 spikes 5 times and neuron 3 spikes 5 times, others 0 -> result_class = 1 (tie, lowest index wins), result_count = 5; count_dout with count_sel = 3 reads 5.
REQ-035 COUNT_WIDTH=3, W=12; spike_in = 4'b0001 every cycle -> result_count = 7 (saturated), result_class = 0.
REQ-036 Hold result_ready = 0 for 20 cycles in DONE and pulse start -> result_valid stays 1, outputs stay stable, the start is ignored; then assert result_ready -> IDLE and busy = 0.
REQ-037 Assert rst mid-RUN -> busy = 0 and result_valid = 0 asynchronously, counters read 0; a subsequent start with window_len = 0 is ignored and busy stays 0.
